// File: rtl/ltssm_pkg.sv
// Shared definitions for the link-training controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ltssm_pkg;

  // State encoding doubles as the ts_info code driven to the TS generators.
  typedef enum logic [7:0] {
    ST_DETECT_QUIET  = 8'h00,
    ST_DETECT_ACTIVE = 8'h01,
    ST_POLL_ACTIVE   = 8'h10,
    ST_POLL_CONFIG   = 8'h11,
    ST_L0            = 8'h20
  } ltssm_state_e;

  localparam logic [7:0] TS1_ID     = 8'h4A;
  localparam logic [7:0] TS2_ID     = 8'h45;
  localparam logic [5:0] SPEED_GEN1 = 6'b000001;

  function automatic logic is_detect(input ltssm_state_e s);
    return (s == ST_DETECT_QUIET) || (s == ST_DETECT_ACTIVE);
  endfunction

endpackage

// File: rtl/ltssm_link_ctrl_ts_rx_lane.sv
// Per-lane count of consecutive matching received training sets.
// Latency: count updates the cycle after a qualified strobe; done is a decode of the count.
// Backpressure: none; every qualified strobe is consumed.
module ts_rx_lane #(
  parameter int TS_RX_CNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic vld_i,
  input  logic is_ts1_i,
  input  logic is_ts2_i,
  input  logic mode_cfg_i,
  output logic done_o
);
  localparam int CW = $clog2(TS_RX_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TS_RX_CNT);

  logic [CW-1:0] cnt_q, cnt_d;

  // TS2 always advances; TS1 advances in Polling.Active and holds in Polling.Config; anything else restarts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (vld_i) begin
      if (is_ts2_i || (is_ts1_i && !mode_cfg_i)) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      end else if (!(is_ts1_i && mode_cfg_i)) begin
        cnt_d = '0;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ltssm_link_ctrl.sv
// Link-training controller: Detect -> Polling -> L0 with contiguous lane-width negotiation.
// Latency: all outputs registered; a state change is visible one cycle after its exit condition.
// Backpressure: ts_update is held until every relevant lane acks; TS inputs are never stalled.
module ltssm_link_ctrl
  import ltssm_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int QUIET_CYC   = 1000,
  parameter int POLL_TO_CYC = 24000,
  parameter int TS_RX_CNT   = 8,
  parameter int TS_TX_CNT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LANES-1:0]     elec_idle_break,
  output logic [LANES-1:0]     rx_det_seq_req,
  input  logic [LANES-1:0]     rx_det_seq_ack,
  input  logic [LANES-1:0]     rx_det_valid,
  input  logic [LANES*128-1:0] ts_i,
  input  logic [LANES-1:0]     ts_i_vld,
  input  logic [LANES-1:0]     tx_ts_sent,
  input  logic                 force_detect,
  output logic [7:0]           ts_info,
  output logic                 ts_update,
  input  logic [LANES-1:0]     ts_update_ack,
  output logic                 ts_stop,
  output logic [LANES-1:0]     lane_mask,
  output logic [4:0]           link_width,
  output logic [5:0]           curr_speed,
  output logic                 linkup
);
  localparam int TXW = $clog2(TS_TX_CNT + 1);
  localparam logic [TXW-1:0] TX_MAX     = TXW'(TS_TX_CNT);
  localparam logic [31:0]    QUIET_LAST = 32'(QUIET_CYC - 1);
  localparam logic [31:0]    POLL_LAST  = 32'(POLL_TO_CYC - 1);

  ltssm_state_e   state_q, state_d;
  logic [31:0]    timer_q, timer_d;
  logic           entry_q, chg;
  logic [LANES-1:0] req_q, req_d, acked_q, acked_d, det_q, det_d, mask_q, mask_d;
  logic [4:0]     width_q, width_d;
  logic           upd_q, upd_d, stop_q, stop_d, linkup_q, linkup_d;
  logic           seen_ts2_q, seen_ts2_d;
  logic [TXW-1:0] tx_cnt_q, tx_cnt_d;

  logic [LANES-1:0] new_ack, acked_all, det_all, mask_calc, upd_mask;
  logic [LANES-1:0] ts_vld_act, lane_is_ts1, lane_is_ts2, lane_done;
  logic [4:0]       width_calc;
  logic             run, all_done, upd_ack_ok, timeout;
  logic             unused_bits;

  // Acks are only taken for outstanding requests and never in the first cycle of a state.
  assign new_ack    = rx_det_seq_ack & req_q & {LANES{!entry_q && (state_q == ST_DETECT_ACTIVE)}};
  assign acked_all  = acked_q | new_ack;
  assign det_all    = det_q | (rx_det_valid & new_ack);
  assign ts_vld_act = ts_i_vld & mask_q &
                      {LANES{!entry_q && ((state_q == ST_POLL_ACTIVE) || (state_q == ST_POLL_CONFIG))}};
  assign all_done   = &(lane_done | ~mask_q);
  assign timeout    = (timer_q == POLL_LAST);
  assign upd_mask   = is_detect(state_q) ? {LANES{1'b1}} : mask_q;
  assign upd_ack_ok = !entry_q && ((ts_update_ack & upd_mask) == upd_mask);
  assign unused_bits = ^{ts_i, tx_ts_sent};

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [7:0] id;
    assign id             = ts_i[128*n+120 +: 8];
    assign lane_is_ts1[n] = (id == TS1_ID);
    assign lane_is_ts2[n] = (id == TS2_ID);
    ts_rx_lane #(.TS_RX_CNT(TS_RX_CNT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (chg),
      .vld_i      (ts_vld_act[n]),
      .is_ts1_i   (lane_is_ts1[n]),
      .is_ts2_i   (lane_is_ts2[n]),
      .mode_cfg_i (state_q == ST_POLL_CONFIG),
      .done_o     (lane_done[n])
    );
  end

  // Negotiated width: length of the unbroken run of detected lanes starting at lane 0.
  always_comb begin
    run        = 1'b1;
    width_calc = 5'd0;
    mask_calc  = '0;
    for (int n = 0; n < LANES; n++) begin
      run          = run & det_all[n];
      mask_calc[n] = run;
      if (run) width_calc = width_calc + 5'd1;
    end
  end

  // Next-state selection; force_detect overrides every other exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DETECT_QUIET:
        if ((timer_q == QUIET_LAST) || (|elec_idle_break)) state_d = ST_DETECT_ACTIVE;
      ST_DETECT_ACTIVE:
        if (&acked_all) state_d = (width_calc == 5'd0) ? ST_DETECT_QUIET : ST_POLL_ACTIVE;
      ST_POLL_ACTIVE:
        if (all_done)     state_d = ST_POLL_CONFIG;
        else if (timeout) state_d = ST_DETECT_QUIET;
      ST_POLL_CONFIG:
        if (all_done && (tx_cnt_q >= TX_MAX)) state_d = ST_L0;
        else if (timeout)                      state_d = ST_DETECT_QUIET;
      ST_L0: state_d = ST_L0;
      default: state_d = ST_DETECT_QUIET;
    endcase
    if (force_detect) state_d = ST_DETECT_QUIET;
    chg = force_detect || (state_d != state_q);
  end

  // Datapath next values: timers, detect bookkeeping, lane mask, TS handshake, TX count.
  always_comb begin
    timer_d    = chg ? 32'd0 : timer_q + 32'd1;
    req_d      = chg ? ((state_d == ST_DETECT_ACTIVE) ? {LANES{1'b1}} : '0) : (req_q & ~new_ack);
    acked_d    = chg ? '0 : acked_all;
    det_d      = chg ? '0 : det_all;
    mask_d     = mask_q;
    width_d    = width_q;
    if (chg) begin
      if ((state_q == ST_DETECT_ACTIVE) && (state_d == ST_POLL_ACTIVE)) begin
        mask_d  = mask_calc;
        width_d = width_calc;
      end else if (is_detect(state_d)) begin
        mask_d  = '0;
        width_d = 5'd0;
      end
    end
    upd_d = upd_q;
    if (upd_q && upd_ack_ok) upd_d = 1'b0;
    if (state_d != state_q)  upd_d = 1'b1;
    stop_d     = is_detect(state_d) || (state_d == ST_L0);
    linkup_d   = (state_d == ST_L0);
    seen_ts2_d = chg ? 1'b0 :
                 (seen_ts2_q || ((state_q == ST_POLL_CONFIG) && |(ts_vld_act & lane_is_ts2)));
    tx_cnt_d   = tx_cnt_q;
    if (chg) tx_cnt_d = '0;
    else if (seen_ts2_q && tx_ts_sent[0] && (tx_cnt_q != TX_MAX)) tx_cnt_d = tx_cnt_q + TXW'(1);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_DETECT_QUIET;
      timer_q    <= 32'd0;
      entry_q    <= 1'b0;
      req_q      <= '0;
      acked_q    <= '0;
      det_q      <= '0;
      mask_q     <= '0;
      width_q    <= 5'd0;
      upd_q      <= 1'b0;
      stop_q     <= 1'b1;
      linkup_q   <= 1'b0;
      seen_ts2_q <= 1'b0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      entry_q    <= chg;
      req_q      <= req_d;
      acked_q    <= acked_d;
      det_q      <= det_d;
      mask_q     <= mask_d;
      width_q    <= width_d;
      upd_q      <= upd_d;
      stop_q     <= stop_d;
      linkup_q   <= linkup_d;
      seen_ts2_q <= seen_ts2_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign ts_info        = state_q;
  assign ts_update      = upd_q;
  assign ts_stop        = stop_q;
  assign linkup         = linkup_q;
  assign lane_mask      = mask_q;
  assign link_width     = width_q;
  assign rx_det_seq_req = req_q;
  assign curr_speed     = SPEED_GEN1;

endmodule

// File: doc/ltssm_link_ctrl.md
# ltssm_link_ctrl

Parametrised link-training controller: the next-generation core of the LTSSM top, generalised to `LANES` lanes with link-width negotiation. It runs Detect.Quiet → Detect.Active → Polling.Active → Polling.Configuration → L0. It drives per-lane receiver-detect requests and the shared TS-generator handshake, and consumes per-lane received TS words. It sits between the lane PHY stubs and the per-lane TS generators.

## Interface
Parameters:
- `LANES`, 4: lane count, 1–16.
- `QUIET_CYC`, 1000: Detect.Quiet timeout, in clk cycles.
- `POLL_TO_CYC`, 24000: Polling.Active / Polling.Configuration timeout, in cycles.
- `TS_RX_CNT`, 8: consecutive matching TSs required per lane.
- `TS_TX_CNT`, 16: TS2s to send after the first TS2 is received.

Ports:
- `clk` in 1: system clock. The block uses this one clock only.
- `rst` in 1: synchronous, active-high reset.
- `elec_idle_break` in LANES: per-lane exit from electrical idle.
- `rx_det_seq_req` out LANES: receiver-detect request, one per lane.
- `rx_det_seq_ack` in LANES: receiver-detect done, one per lane.
- `rx_det_valid` in LANES: receiver-detect result, sampled at ack.
- `ts_i` in LANES*128: received TS words; lane n occupies [128n+127:128n].
- `ts_i_vld` in LANES: received-TS strobe, one per lane.
- `tx_ts_sent` in LANES: pulse per TS transmitted, one per lane.
- `force_detect` in 1: return to Detect.Quiet from any state.
- `ts_info` out 8: TS content selector; [7:4] state, [3:0] substate.
- `ts_update` out 1: TS-generator reload request.
- `ts_update_ack` in LANES: TS-generator reload acknowledge, one per lane.
- `ts_stop` out 1: stop TS transmission. High in L0 and in DETECT_*.
- `lane_mask` out LANES: active (negotiated) lanes.
- `link_width` out 5: number of active lanes.
- `curr_speed` out 6: current rate; constant 6'b000001 (Gen1).
- `linkup` out 1: high in L0.

## Operation
- States and `ts_info` codes: DETECT_QUIET 8'h00, DETECT_ACTIVE 8'h01, POLL_ACTIVE 8'h10, POLL_CONFIG 8'h11, L0 8'h20.
- TS format: bits [127:120] carry the identifier. 8'h4A is TS1; 8'h45 is TS2.
- DETECT_QUIET:
  - The timer counts up.
  - Exit to DETECT_ACTIVE when the timer reaches QUIET_CYC-1, or when any bit of `elec_idle_break` is set.
- DETECT_ACTIVE:
  - Raise all `rx_det_seq_req` bits.
  - Each bit drops the cycle after its own ack.
  - Latch `rx_det_valid[n]` in the cycle `rx_det_seq_ack[n]` is high.
  - Once all lanes have acked:
    - `link_width` = length of the contiguous run of detected lanes starting at lane 0.
    - `lane_mask` = (1<<width)-1.
    - If width is 0, go to DETECT_QUIET; otherwise go to POLL_ACTIVE.
- Per-lane receive counter (`ts_rx_lane`), saturating at TS_RX_CNT. On a `ts_i_vld` cycle:
  - In POLL_ACTIVE: TS1 or TS2 increments; any other identifier clears.
  - In POLL_CONFIG: TS2 increments; TS1 holds; any other identifier clears.
  - On every state entry: all counters clear.
- POLL_ACTIVE:
  - The TS generators send TS1.
  - Exit to POLL_CONFIG when every lane in `lane_mask` has reached TS_RX_CNT.
  - If the timer reaches POLL_TO_CYC-1 first, go to DETECT_QUIET.
- POLL_CONFIG:
  - The TS generators send TS2.
  - The TX counter counts `tx_ts_sent[0]` pulses, but only after the first TS2 has been received on any active lane.
  - Exit to L0 when every active lane has reached TS_RX_CNT and the TX count is at least TS_TX_CNT.
  - Timeout goes to DETECT_QUIET.
- L0: `linkup`=1; `ts_stop`=1. Stay until `force_detect`.
- Reset and `force_detect`:
  - Enter DETECT_QUIET.
  - `lane_mask`=0, `link_width`=0.
  - All counters clear.
- If a state exit condition and `force_detect` occur in the same cycle, `force_detect` wins.

## Timing
- Reset values:
  - `ts_info`=8'h00.
  - `ts_update`=0, `rx_det_seq_req`=0.
  - `ts_stop`=1.
  - `lane_mask`=0, `link_width`=0.
  - `linkup`=0.
  - `curr_speed`=6'b000001.
- Every output is registered. A state change is visible 1 cycle after its exit condition.
- `ts_update` handshake:
  - `ts_update` rises in the same cycle `ts_info` changes.
  - It is held until `ts_update_ack & lane_mask` equals `lane_mask`. In DETECT_* states the full-ones mask is used instead.
  - It falls the cycle after that.
  - A new `ts_info` change while the handshake is pending updates `ts_info` and keeps `ts_update` high.
- An ack or TS received in the same cycle as a state entry is ignored.
- Inactive lanes:
  - `ts_i_vld` on an inactive lane is ignored.
  - Inactive lanes' `rx_det_seq_req` stays low outside DETECT_ACTIVE.

## Structure
- Package `ltssm_pkg`:
  - State codes.
  - TS1/TS2 identifier constants.
  - Gen1 speed constant.
- Sub-module `ts_rx_lane`, instantiated LANES times:
  - Inputs: identifier decode, state-entry clear, mode (POLL_ACTIVE / POLL_CONFIG).
  - Output: `done` (count == TS_RX_CNT).

## Test plan
- LANES=4, all lanes detected, ideal partner, 8 TS1 then 8 TS2 per lane, 16 `tx_ts_sent` pulses → `linkup`=1, `link_width`=4, `lane_mask`=4'hF.
- Lanes 0, 1, 3 detected → `link_width`=2, `lane_mask`=4'h3. Lanes 2/3 TS traffic is ignored and L0 is reached.
- No lanes detected → back to DETECT_QUIET, then DETECT_ACTIVE again after QUIET_CYC cycles.
- POLL_ACTIVE: lane 1 receives 7 TS1, then a bad identifier, then nothing → DETECT_QUIET at POLL_TO_CYC.
- `ts_update` held while `ts_update_ack`=4'b0111. It falls one cycle after `ts_update_ack`=4'hF.
- `force_detect` in L0 → `linkup`=0 and `ts_info`=8'h00 next cycle. Mid-handshake `rst` clears all outputs.
